// File: rtl/intlv_filo_if.sv
// Bundle of the drain job handshake, FILO read ports and serial output stream.
// The drain block uses the slave modport. The driver and FILO side use the master modport.
interface intlv_filo_if;
    logic        start;
    logic [13:0] e_size;
    logic [13:0] l_size;
    logic        filoA_rdy4rd;
    logic        filoB_rdy4rd;
    logic        filoA_rdA_en;
    logic        filoB_rdA_en;
    logic [9:0]  filoA_rdA_data;
    logic [9:0]  filoB_rdA_data;
    logic        out_bit;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    modport slave (
        input  start, e_size, l_size,
        input  filoA_rdy4rd, filoB_rdy4rd, filoA_rdA_data, filoB_rdA_data,
        input  out_ready,
        output filoA_rdA_en, filoB_rdA_en,
        output out_bit, out_valid, out_last, busy, done
    );

    modport master (
        output start, e_size, l_size,
        output filoA_rdy4rd, filoB_rdy4rd, filoA_rdA_data, filoB_rdA_data,
        output out_ready,
        input  filoA_rdA_en, filoB_rdA_en,
        input  out_bit, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/intlv_filo_drain.sv
// Drains L buffered bits from two interleaved FILOs (A, B, A, ...) as an E-bit serial stream.
// The stream is zero-padded when E > L. When E < L, the surplus words are popped and discarded.
module intlv_filo_drain (
    input  logic         clk,
    input  logic         rst_n,
    intlv_filo_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        PAD   = 3'd4,
        FLUSH = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state_q,     state_d;
    logic [13:0] e_q,         e_d;
    logic [13:0] l_q,         l_d;
    logic [13:0] out_cnt_q,   out_cnt_d;
    logic [13:0] rd_bits_q,   rd_bits_d;
    logic [9:0]  sreg_q,      sreg_d;
    logic [3:0]  left_q,      left_d;
    logic        sel_q,       sel_d;
    logic        ph_q,        ph_d;
    logic        out_valid_q, out_valid_d;
    logic        out_bit_q,   out_bit_d;
    logic        out_last_q,  out_last_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    logic        sel_rdy;
    logic        xfer;
    logic        pop;
    logic [13:0] oc_inc;
    logic [13:0] rb_inc;
    logic [13:0] rb_round;

    function automatic logic [13:0] sat_add(input logic [13:0] a,
                                            input logic [13:0] b,
                                            input logic [13:0] lim);
        logic [14:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, lim}) ? lim : s[13:0];
    endfunction

    assign sel_rdy  = sel_q ? bus.filoB_rdy4rd : bus.filoA_rdy4rd;
    assign xfer     = out_valid_q && bus.out_ready;
    // A pop is a single-cycle strobe. It is decoded from the registered state and gated by the FILO's ready.
    assign pop      = ((state_q == FETCH) || (state_q == FLUSH && !ph_q)) && sel_rdy;
    assign oc_inc   = out_cnt_q + 14'd1;
    assign rb_inc   = sat_add(rd_bits_q, 14'd1, l_q);
    // Truncation skips the unread tail of the current word, so flushing continues from the next word boundary.
    assign rb_round = sat_add(rb_inc, {10'd0, left_q - 4'd1}, l_q);

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        l_d       = l_q;
        out_cnt_d = out_cnt_q;
        rd_bits_d = rd_bits_q;
        sreg_d    = sreg_q;
        left_d    = left_q;
        sel_d     = sel_q;
        ph_d      = ph_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    e_d       = bus.e_size;
                    l_d       = bus.l_size;
                    out_cnt_d = 14'd0;
                    rd_bits_d = 14'd0;
                    sreg_d    = 10'd0;
                    left_d    = 4'd0;
                    sel_d     = 1'b0;
                    ph_d      = 1'b0;
                    if (bus.e_size != 14'd0 && bus.l_size != 14'd0)
                        state_d = FETCH;
                    else if (bus.e_size != 14'd0)
                        state_d = PAD;
                    else if (bus.l_size != 14'd0)
                        state_d = FLUSH;
                    else
                        state_d = DONE;
                end
            end
            FETCH: begin
                if (sel_rdy)
                    state_d = WAIT;
            end
            WAIT: begin
                sreg_d  = sel_q ? bus.filoB_rdA_data : bus.filoA_rdA_data;
                sel_d   = ~sel_q;
                left_d  = 4'd10;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (xfer) begin
                    out_cnt_d = oc_inc;
                    rd_bits_d = rb_inc;
                    sreg_d    = {sreg_q[8:0], 1'b0};
                    left_d    = left_q - 4'd1;
                    if (oc_inc == e_q) begin
                        sreg_d = 10'd0;
                        left_d = 4'd0;
                        if (rb_inc >= l_q) begin
                            state_d = DONE;
                        end else begin
                            rd_bits_d = rb_round;
                            ph_d      = 1'b0;
                            state_d   = (rb_round >= l_q) ? DONE : FLUSH;
                        end
                    end else if (rb_inc == l_q) begin
                        sreg_d  = 10'd0;
                        left_d  = 4'd0;
                        state_d = PAD;
                    end else if (left_q == 4'd1) begin
                        state_d = FETCH;
                    end
                end
            end
            PAD: begin
                if (xfer) begin
                    out_cnt_d = oc_inc;
                    if (oc_inc == e_q)
                        state_d = DONE;
                end
            end
            FLUSH: begin
                if (!ph_q) begin
                    if (sel_rdy) begin
                        rd_bits_d = sat_add(rd_bits_q, 14'd10, l_q);
                        sel_d     = ~sel_q;
                        ph_d      = 1'b1;
                    end
                end else begin
                    ph_d = 1'b0;
                    if (rd_bits_q >= l_q)
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from next-state values so they line up with the state they describe.
        out_valid_d = (state_d == SHIFT) || (state_d == PAD);
        out_bit_d   = (state_d == SHIFT) && sreg_d[9];
        out_last_d  = out_valid_d && (out_cnt_d == (e_d - 14'd1));
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            e_q         <= 14'd0;
            l_q         <= 14'd0;
            out_cnt_q   <= 14'd0;
            rd_bits_q   <= 14'd0;
            sreg_q      <= 10'd0;
            left_q      <= 4'd0;
            sel_q       <= 1'b0;
            ph_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            l_q         <= l_d;
            out_cnt_q   <= out_cnt_d;
            rd_bits_q   <= rd_bits_d;
            sreg_q      <= sreg_d;
            left_q      <= left_d;
            sel_q       <= sel_d;
            ph_q        <= ph_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.filoA_rdA_en = pop && !sel_q;
    assign bus.filoB_rdA_en = pop &&  sel_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_bit      = out_bit_q;
    assign bus.out_last     = out_last_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_intlv_filo_drain.sv
// Directed bench for intlv_filo_drain. Two FILO models feed word tables, and a negedge monitor records the stream.
// Each scenario task compares the recorded bits, pops and done pulses against hand-computed values.
module tb_intlv_filo_drain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intlv_filo_if bus();

    intlv_filo_drain dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // FILO models: the word is returned on the edge after rdA_en.
    logic [9:0] a_words [8];
    logic [9:0] b_words [8];
    int popA = 0, popB = 0, a_base = 0, b_base = 0;

    always @(posedge clk) begin
        if (bus.filoA_rdA_en) begin
            bus.filoA_rdA_data <= a_words[(popA - a_base) % 8];
            popA <= popA + 1;
        end
        if (bus.filoB_rdA_en) begin
            bus.filoB_rdA_data <= b_words[(popB - b_base) % 8];
            popB <= popB + 1;
        end
    end

    // Stream monitor sampled on the falling edge.
    bit   bit_q[$];
    int   last_q[$];
    int   done_cnt = 0, both_en = 0, stab_err = 0, lastv_err = 0;
    logic prev_v = 1'b0, prev_r = 1'b0, prev_b = 1'b0;

    always @(negedge clk) begin
        if (bus.filoA_rdA_en && bus.filoB_rdA_en) both_en <= both_en + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.out_last && !bus.out_valid) lastv_err <= lastv_err + 1;
        if (bus.out_valid && bus.out_ready) begin
            if (bus.out_last) last_q.push_back(bit_q.size());
            bit_q.push_back(bus.out_bit);
        end
        if (rst_n && prev_v && !prev_r && (!bus.out_valid || bus.out_bit !== prev_b))
            stab_err <= stab_err + 1;
        prev_v <= bus.out_valid;
        prev_r <= bus.out_ready;
        prev_b <= bus.out_bit;
    end

    task automatic run_job(input logic [13:0] e, input logic [13:0] l,
                           input bit rnd, input bit bstall,
                           output int nb, output logic [63:0] got,
                           output int lidx, output int nlast, output int dn,
                           output int pa, output int pb, output bit to, output int spops);
        int b0, l0, d0, a0, bb0, stall;
        bit fin;
        b0 = bit_q.size(); l0 = last_q.size(); d0 = done_cnt;
        a0 = popA; bb0 = popB; a_base = popA; b_base = popB;
        stall = 0; fin = 1'b0; spops = -1;
        bus.filoB_rdy4rd = !bstall;
        @(posedge clk); #1;
        bus.e_size = e; bus.l_size = l; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bstall && (bit_q.size() - b0) >= 10) begin
                if (stall == 5 && !bus.filoB_rdy4rd) begin
                    spops = popB - bb0;
                    bus.filoB_rdy4rd = 1'b1;
                end else if (stall < 5) begin
                    stall++;
                end
            end
            @(posedge clk); #1;
            if (done_cnt != d0) fin = 1'b1;
        end
        to = !fin;
        bus.out_ready = 1'b1;
        bus.filoB_rdy4rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nb = bit_q.size() - b0;
        got = '0;
        for (int i = 0; i < nb && i < 64; i++) got = {got[62:0], bit_q[b0 + i]};
        nlast = last_q.size() - l0;
        lidx = (nlast > 0) ? (last_q[l0] - b0) : -1;
        dn = done_cnt - d0;
        pa = popA - a0;
        pb = popB - bb0;
        $display("[TB] job E=%0d L=%0d bits=%0d last_idx=%0d popsA=%0d popsB=%0d done=%0d stream=%h",
                 e, l, nb, lidx, pa, pb, dn, got);
    endtask

    task automatic test_reset();
        tests++;
        if ({bus.busy, bus.done, bus.out_valid, bus.out_bit, bus.out_last,
             bus.filoA_rdA_en, bus.filoB_rdA_en} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {bus.busy, bus.done, bus.out_valid, bus.out_bit, bus.out_last,
                      bus.filoA_rdA_en, bus.filoB_rdA_en});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.busy !== 1'b0 || (popA + popB) != 0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b pops=%0d required busy=0 pops=0", bus.busy, popA + popB);
        end
    endtask

    task automatic test_basic();
        int nb, lidx, nlast, dn, pa, pb, sp; logic [63:0] got; bit to;
        a_words[0] = 10'h3FF; b_words[0] = 10'h000;
        run_job(14'd20, 14'd20, 1'b0, 1'b0, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to) begin fails++; $display("FAIL basic_timeout: done not seen"); end
        tests++; if (nb != 20 || got[19:0] !== 20'hFFC00) begin
            fails++; $display("FAIL basic_stream: got %0d bits %h required 20 bits FFC00", nb, got); end
        tests++; if (lidx != 19 || nlast != 1) begin
            fails++; $display("FAIL basic_last: got idx %0d count %0d required idx 19 count 1", lidx, nlast); end
        tests++; if (dn != 1 || pa != 1 || pb != 1) begin
            fails++; $display("FAIL basic_pops_done: got done=%0d A=%0d B=%0d required 1/1/1", dn, pa, pb); end
    endtask

    task automatic test_pad();
        int nb, lidx, nlast, dn, pa, pb, sp; logic [63:0] got; bit to;
        logic [24:0] exp;
        exp = {10'h155, 10'h2A3, 5'b00000};
        a_words[0] = 10'h155; b_words[0] = 10'h2A3;
        run_job(14'd25, 14'd20, 1'b0, 1'b0, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to || nb != 25 || got[24:0] !== exp) begin
            fails++; $display("FAIL pad_stream: got %0d bits %h required 25 bits %h", nb, got, exp); end
        tests++; if (lidx != 24 || nlast != 1) begin
            fails++; $display("FAIL pad_last: got idx %0d count %0d required idx 24 count 1", lidx, nlast); end
        tests++; if (dn != 1 || pa + pb != 2) begin
            fails++; $display("FAIL pad_pops_done: got done=%0d pops=%0d required 1/2", dn, pa + pb); end
    endtask

    task automatic test_flush();
        int nb, lidx, nlast, dn, pa, pb, sp; logic [63:0] got; bit to;
        a_words[0] = 10'h2C5; a_words[1] = 10'h111; b_words[0] = 10'h3FF;
        run_job(14'd8, 14'd30, 1'b0, 1'b0, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to || nb != 8 || got[7:0] !== 8'hB1) begin
            fails++; $display("FAIL flush_stream: got %0d bits %h required 8 bits B1", nb, got); end
        tests++; if (lidx != 7) begin
            fails++; $display("FAIL flush_last: got idx %0d required 7", lidx); end
        tests++; if (dn != 1 || pa != 2 || pb != 1) begin
            fails++; $display("FAIL flush_pops_done: got done=%0d A=%0d B=%0d required 1/2/1", dn, pa, pb); end
    endtask

    task automatic test_truncate();
        int nb, lidx, nlast, dn, pa, pb, sp; logic [63:0] got; bit to;
        a_words[0] = 10'h2AA; b_words[0] = 10'h3C0;
        run_job(14'd13, 14'd13, 1'b0, 1'b0, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to || nb != 13 || got[12:0] !== 13'h1557) begin
            fails++; $display("FAIL trunc_stream: got %0d bits %h required 13 bits 1557", nb, got); end
        tests++; if (dn != 1 || pa != 1 || pb != 1 || lidx != 12) begin
            fails++; $display("FAIL trunc_pops_done: got done=%0d A=%0d B=%0d last=%0d required 1/1/1/12",
                              dn, pa, pb, lidx); end
    endtask

    task automatic test_zero_sizes();
        int nb, lidx, nlast, dn, pa, pb, sp; logic [63:0] got; bit to;
        a_words[0] = 10'h3FF; b_words[0] = 10'h3FF;
        run_job(14'd0, 14'd0, 1'b0, 1'b0, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to || dn != 1 || nb != 0 || pa + pb != 0) begin
            fails++; $display("FAIL zero_e0_l0: got done=%0d bits=%0d pops=%0d required 1/0/0", dn, nb, pa + pb); end
        run_job(14'd5, 14'd0, 1'b0, 1'b0, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to || dn != 1 || nb != 5 || got[4:0] !== 5'b0 || lidx != 4 || pa + pb != 0) begin
            fails++; $display("FAIL zero_l0_pad: got done=%0d bits=%0d stream=%h last=%0d pops=%0d required 1/5/0/4/0",
                              dn, nb, got, lidx, pa + pb); end
        run_job(14'd0, 14'd15, 1'b0, 1'b0, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to || dn != 1 || nb != 0 || pa != 1 || pb != 1) begin
            fails++; $display("FAIL zero_e0_flush: got done=%0d bits=%0d A=%0d B=%0d required 1/0/1/1", dn, nb, pa, pb); end
    endtask

    task automatic test_stall();
        int nb, lidx, nlast, dn, pa, pb, sp, s0; logic [63:0] got; bit to;
        a_words[0] = 10'h35A; b_words[0] = 10'h0F3;
        s0 = stab_err;
        run_job(14'd20, 14'd20, 1'b1, 1'b1, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to || nb != 20 || got[19:0] !== {10'h35A, 10'h0F3}) begin
            fails++; $display("FAIL stall_stream: got %0d bits %h required 20 bits %h", nb, got, {10'h35A, 10'h0F3}); end
        tests++; if (sp != 0) begin
            fails++; $display("FAIL stall_no_pop: got %0d B pops during stall required 0", sp); end
        tests++; if (stab_err != s0) begin
            fails++; $display("FAIL stall_stable: got %0d unstable cycles required 0", stab_err - s0); end
        tests++; if (dn != 1 || pa != 1 || pb != 1 || lidx != 19) begin
            fails++; $display("FAIL stall_pops_done: got done=%0d A=%0d B=%0d last=%0d required 1/1/1/19",
                              dn, pa, pb, lidx); end
    endtask

    task automatic test_reset_mid();
        int nb, lidx, nlast, dn, pa, pb, sp, b0, d0, pa0, pb0; logic [63:0] got; bit to, hit;
        a_words[0] = 10'h3FF; b_words[0] = 10'h000;
        a_base = popA; b_base = popB;
        b0 = bit_q.size(); d0 = done_cnt; hit = 1'b0;
        @(posedge clk); #1;
        bus.e_size = 14'd20; bus.l_size = 14'd20; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk); #1;
            if ((bit_q.size() - b0) >= 5) hit = 1'b1;
        end
        tests++; if (!hit) begin fails++; $display("FAIL rstmid_timeout: 5 bits not seen"); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.out_valid, bus.out_bit, bus.out_last,
             bus.filoA_rdA_en, bus.filoB_rdA_en} !== 7'b0) begin
            fails++;
            $display("FAIL rstmid_outputs: got %b required 0000000",
                     {bus.busy, bus.done, bus.out_valid, bus.out_bit, bus.out_last,
                      bus.filoA_rdA_en, bus.filoB_rdA_en});
        end
        pa0 = popA; pb0 = popB;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (done_cnt != d0 || popA != pa0 || popB != pb0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_abort: got done=%0d pops=%0d busy=%b required 0/0/0",
                              done_cnt - d0, (popA - pa0) + (popB - pb0), bus.busy); end
        a_words[0] = 10'h1E5; b_words[0] = 10'h000;
        run_job(14'd10, 14'd10, 1'b0, 1'b0, nb, got, lidx, nlast, dn, pa, pb, to, sp);
        tests++; if (to || nb != 10 || got[9:0] !== 10'h1E5 || pa != 1 || pb != 0 || dn != 1) begin
            fails++; $display("FAIL rstmid_restart: got bits=%0d stream=%h A=%0d B=%0d done=%0d required 10/1E5/1/0/1",
                              nb, got, pa, pb, dn); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.e_size = 14'd0;
        bus.l_size = 14'd0;
        bus.filoA_rdy4rd = 1'b1;
        bus.filoB_rdy4rd = 1'b1;
        bus.out_ready = 1'b1;
        #12;
        test_reset();
        test_basic();
        test_pad();
        test_flush();
        test_truncate();
        test_zero_sizes();
        test_stall();
        test_reset_mid();
        tests++; if (both_en != 0) begin
            fails++; $display("FAIL dual_pop: got %0d cycles with both rdA_en required 0", both_en); end
        tests++; if (lastv_err != 0) begin
            fails++; $display("FAIL last_without_valid: got %0d cycles required 0", lastv_err); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/intlv_filo_drain.md
INTLV_FILO_DRAIN -- requirements
Module: intlv_filo_drain

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (asynchronous assert, active low).
REQ-002 clk  input  1  block clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle pulse; begins one drain job; ignored while busy=1.
REQ-005 e_size  input  14  number of output bits E; sampled on accepted start.
REQ-006 l_size  input  14  number of valid buffered bits L across both FILOs; sampled on accepted start.
REQ-007 filoA_rdy4rd / filoB_rdy4rd  input  1 each  FILO holds readable data.
REQ-008 filoA_rdA_en / filoB_rdA_en  output  1 each  pop one 10-bit word.
REQ-009 filoA_rdA_data / filoB_rdA_data  input  10 each  popped word, valid one cycle after rdA_en.
REQ-010 out_bit  output  1  serial output bit.
REQ-011 out_valid  output  1  out_bit valid.
REQ-012 out_ready  input  1  downstream accepts; transfer when out_valid and out_ready are both 1.
REQ-013 out_last  output  1  marks bit E-1.
REQ-014 busy  output  1  job in progress.
REQ-015 done  output  1  single-cycle pulse at job end.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, SHIFT, PAD, FLUSH, DONE.
REQ-017 IDLE: on start, latch E and L, clear counters, set word select to A; go to FETCH if E>0 and L>0, PAD if E>0 and L=0, FLUSH if E=0 and L>0, DONE if E=0 and L=0.
REQ-018 Word selection SHALL alternate A, B, A, B, ... starting at A for every job.
REQ-019 FETCH: assert the selected rdA_en for exactly one cycle when the selected rdy4rd=1, then go to WAIT; if rdy4rd=0, stall in FETCH with no rdA_en asserted.
REQ-020 WAIT: capture the selected rdA_data into a 10-bit shift register, toggle word select, go to SHIFT.
REQ-021 SHIFT: present bits MSB first (bit 9 down to bit 0); each handshake advances out_cnt and rd_bits by 1.
REQ-022 Bits of the final word beyond L SHALL be discarded without output: when rd_bits reaches L, the remaining shift-register bits are dropped.
REQ-023 After each handshake in SHIFT, the next state SHALL be: DONE if out_cnt=E and rd_bits>=L; FLUSH if out_cnt=E and rd_bits<L; PAD if out_cnt<E and rd_bits=L; FETCH if the current word is exhausted; otherwise stay in SHIFT.
REQ-024 PAD: out_bit=0, out_valid=1, until out_cnt=E, then go to DONE (E>L zero padding).
REQ-025 FLUSH: pop remaining words (alternation continues, rdy4rd honoured, one pop per two cycles), add 10 to rd_bits per pop with no output, until rd_bits>=L, then go to DONE (E<L truncation; both FILOs are left empty).
REQ-026 DONE: pulse done for one cycle, go to IDLE.
REQ-027 out_last SHALL equal 1 exactly when out_valid=1 and out_cnt=E-1.
REQ-028 out_valid SHALL remain 1 with out_bit stable while out_ready=0.
REQ-029 out_valid SHALL be 0 in IDLE, FETCH, WAIT, FLUSH, and DONE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 out_cnt and rd_bits SHALL be 14 bits wide, and rd_bits SHALL saturate at L.
REQ-032 At most one rdA_en SHALL be asserted per cycle.

Reset
REQ-033 While rst_n=0: state=IDLE, all outputs 0, counters 0, shift register 0, word select A.
REQ-034 Reset asserted mid-job SHALL abort the job immediately with no done pulse; no rdA_en is issued until a new start after reset release.

Verification
REQ-035 E=20, L=20, A word 10'h3FF, B word 10'h000, out_ready=1 -> 10 ones then 10 zeros, out_last on bit 19, one done pulse, 2 pops total.
REQ-036 E=25, L=20 -> 20 data bits followed by 5 zero bits, out_last on bit 24, 2 pops total.
REQ-037 E=8, L=30 -> 8 bits (MSBs of A word 0) are output, then FLUSH pops B then A with no output, 3 pops total, and done follows.
REQ-038 E=13, L=13, A word 10'h2AA, B word 10'h3C0 -> output 1010101010 followed by 111; the remaining 7 B bits are dropped, and done follows.
REQ-039 out_ready toggled randomly, and filoB_rdy4rd held 0 for 5 cycles before the second fetch -> no bit is lost or duplicated, FETCH stalls 5 cycles, and out_bit is stable while stalled.
REQ-040 rst_n pulsed low during SHIFT -> outputs 0 within the reset cycle, no done pulse; a subsequent start with E=10, L=10 completes normally, starting from FILO A.
